// File: rtl/cnn_stage_sequencer.sv
// Layer sequencer: runs conv -> pool -> GAP -> FC with one-cycle registered launch pulses and a per-stage watchdog.
// Stage done is ignored in the launch cycle; start is only honoured in IDLE or ERR and is never queued.
module cnn_stage_sequencer #(
    parameter int STAGE_TIMEOUT = 100000,
    parameter int TO_W          = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               conv_start,
    output logic               pool_start,
    output logic               gap_start,
    output logic               fc_start,
    input  logic               conv_done,
    input  logic               pool_done,
    input  logic               gap_done,
    input  logic               fc_done,
    input  logic signed [15:0] fc_score,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [3:0]         error_stage,
    output logic [2:0]         debug_state,
    output logic [3:0]         active_stage,
    output logic signed [15:0] final_score,
    output logic               class_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_POOL = 3'd2,
        S_GAP  = 3'd3,
        S_FC   = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(STAGE_TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wd_cnt;
    logic            first_cycle;
    logic            stage_done;
    logic            timeout;
    logic            launch;

    // The launch pulse marks the first cycle of a stage, where a leftover done must be rejected.
    assign first_cycle = conv_start | pool_start | gap_start | fc_start;

    always_comb begin
        active_stage = 4'b0000;
        stage_done   = 1'b0;
        case (state)
            S_CONV: begin active_stage = 4'b0001; stage_done = conv_done; end
            S_POOL: begin active_stage = 4'b0010; stage_done = pool_done; end
            S_GAP:  begin active_stage = 4'b0100; stage_done = gap_done;  end
            S_FC:   begin active_stage = 4'b1000; stage_done = fc_done;   end
            default: ;
        endcase
        if (first_cycle) begin
            stage_done = 1'b0;
        end
    end

    assign busy        = |active_stage;
    assign done        = (state == S_DONE);
    assign debug_state = state;
    assign timeout     = busy && !stage_done && (wd_cnt == WD_LAST);
    assign launch      = (state_nxt == S_CONV) && (state != S_CONV);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR: if (start) state_nxt = S_CONV;
            S_CONV: if (stage_done) state_nxt = S_POOL; else if (timeout) state_nxt = S_ERR;
            S_POOL: if (stage_done) state_nxt = S_GAP;  else if (timeout) state_nxt = S_ERR;
            S_GAP:  if (stage_done) state_nxt = S_FC;   else if (timeout) state_nxt = S_ERR;
            S_FC:   if (stage_done) state_nxt = S_DONE; else if (timeout) state_nxt = S_ERR;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wd_cnt      <= '0;
            conv_start  <= 1'b0;
            pool_start  <= 1'b0;
            gap_start   <= 1'b0;
            fc_start    <= 1'b0;
            error       <= 1'b0;
            error_stage <= 4'b0000;
            final_score <= 16'sd0;
            class_out   <= 1'b0;
        end else begin
            state      <= state_nxt;
            conv_start <= launch;
            pool_start <= (state_nxt == S_POOL) && (state != S_POOL);
            gap_start  <= (state_nxt == S_GAP)  && (state != S_GAP);
            fc_start   <= (state_nxt == S_FC)   && (state != S_FC);

            // Any state change restarts the watchdog, so each stage starts counting from zero.
            if (state_nxt != state) begin
                wd_cnt <= '0;
            end else if (busy) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (timeout) begin
                error       <= 1'b1;
                error_stage <= active_stage;
            end else if (launch) begin
                error       <= 1'b0;
                error_stage <= 4'b0000;
            end

            if ((state == S_FC) && stage_done) begin
                final_score <= fc_score;
                class_out   <= (fc_score > 16'sd0);
            end
        end
    end

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Scoreboard bench: each run's expected pulse/done/error events are derived from stage latencies and queued; a monitor pops them.
module tb_cnn_stage_sequencer;

    localparam int T  = 64;
    localparam int TW = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [3:0]         sdone;
    logic signed [15:0] fc_score;
    logic               conv_start, pool_start, gap_start, fc_start;
    logic               busy, done, error, class_out;
    logic [3:0]         error_stage, active_stage;
    logic [2:0]         debug_state;
    logic signed [15:0] final_score;
    logic [3:0]         sp;

    cnn_stage_sequencer #(.STAGE_TIMEOUT(T), .TO_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .conv_start(conv_start), .pool_start(pool_start), .gap_start(gap_start), .fc_start(fc_start),
        .conv_done(sdone[0]), .pool_done(sdone[1]), .gap_done(sdone[2]), .fc_done(sdone[3]),
        .fc_score(fc_score), .busy(busy), .done(done), .error(error), .error_stage(error_stage),
        .debug_state(debug_state), .active_stage(active_stage), .final_score(final_score),
        .class_out(class_out)
    );

    always #5 clk = ~clk;
    assign sp = {fc_start, gap_start, pool_start, conv_start};

    typedef struct {
        int                 kind;   // 0..3 stage launch, 4 run done, 5 watchdog error
        int                 cyc;
        logic [2:0]         dbg;
        logic [3:0]         act;
        logic               bsy;
        logic               err;
        logic [3:0]         est;
        logic signed [15:0] sc;
        logic               cls;
    } ev_t;

    ev_t                exp_q [$];
    int                 cyc;
    int                 nchecks;
    int                 npass;
    int unsigned        lat [4];
    bit                 lvl [4];
    bit                 pre_conv;
    logic signed [15:0] m_score;
    logic               m_cls;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: still running at %0t, expected finish earlier", $time);
        $fatal(1);
    end

    // Stage engine models: done comes lat cycles after the launch pulse, as a pulse or a held level.
    initial begin : responder
        int k [4];
        bit armed [4];
        sdone = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            k[s]     = 0;
            armed[s] = 1'b0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int s = 0; s < 4; s++) begin
                if (sp[s]) begin
                    if (lat[s] == 0) begin
                        sdone[s] = 1'b1;
                        armed[s] = 1'b0;
                    end else begin
                        sdone[s] = 1'b0;
                        k[s]     = int'(lat[s]);
                        armed[s] = 1'b1;
                    end
                end else if (armed[s]) begin
                    k[s]--;
                    if (k[s] == 0) begin
                        sdone[s] = 1'b1;
                        armed[s] = 1'b0;
                    end
                end else if (!lvl[s]) begin
                    sdone[s] = 1'b0;
                end
            end
            if (pre_conv) sdone[0] = 1'b1;
        end
    end

    function automatic logic [63:0] outs();
        return {29'd0, conv_start, pool_start, gap_start, fc_start, busy, done, error,
                error_stage, debug_state, active_stage, final_score, class_out};
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        nchecks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind == kind && e.cyc == cyc && e.dbg === debug_state && e.act === active_stage &&
            e.bsy === busy && e.err === error && e.est === error_stage &&
            e.sc === final_score && e.cls === class_out)
            npass++;
        else
            $display("FAIL event_%0d: got kind %0d cyc %0d state %0d act %b busy %b err %b est %b score %0d cls %b; expected kind %0d cyc %0d state %0d act %b busy %b err %b est %b score %0d cls %b",
                     e.kind, kind, cyc, debug_state, active_stage, busy, error, error_stage, final_score, class_out,
                     e.kind, e.cyc, e.dbg, e.act, e.bsy, e.err, e.est, e.sc, e.cls);
    endtask

    initial begin : monitor
        bit err_q;
        err_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                err_q = error;
                continue;
            end
            for (int s = 0; s < 4; s++) if (sp[s]) check_ev(s);
            if (done) check_ev(4);
            if (error && !err_q) check_ev(5);
            err_q = error;
        end
    end

    task automatic push_ev(input int kind, input int c, input logic [2:0] dbg, input logic [3:0] act,
                           input logic bsy, input logic err, input logic [3:0] est);
        ev_t e;
        e.kind = kind; e.cyc = c; e.dbg = dbg; e.act = act; e.bsy = bsy;
        e.err = err; e.est = est; e.sc = m_score; e.cls = m_cls;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input int unsigned a, input int unsigned b, input int unsigned c,
                           input int unsigned d, input logic [3:0] lv);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
        for (int s = 0; s < 4; s++) lvl[s] = lv[s];
    endtask

    // Called at a negedge with the DUT in IDLE or ERR; returns at a negedge in IDLE or ERR.
    task automatic run(input logic signed [15:0] sc, input bit mid, input bit pre, input bit do_rst);
        int e, e0, eff, last, mid_n, rst_at;
        int ent [4];
        bit ab;
        if (pre) begin
            pre_conv = 1'b1;
            @(negedge clk);
        end
        e0 = cyc + 1;
        e  = e0;
        ab = 1'b0;
        for (int s = 0; s < 4; s++) ent[s] = 0;
        for (int s = 0; s < 4 && !ab; s++) begin
            ent[s] = e;
            push_ev(s, e, 3'(s + 1), 4'(1 << s), 1'b1, 1'b0, 4'd0);
            eff = (lat[s] == 0) ? 1 : int'(lat[s]);
            if (eff + 1 <= T) begin
                e += eff + 1;
            end else begin
                e += T;
                push_ev(5, e, 3'd6, 4'd0, 1'b0, 1'b1, 4'(1 << s));
                ab = 1'b1;
            end
        end
        if (!ab) begin
            m_score = sc;
            m_cls   = (sc > 0);
            push_ev(4, e, 3'd5, 4'd0, 1'b0, 1'b0, 4'd0);
        end
        last   = ab ? e : e + 1;
        mid_n  = mid ? int'($urandom_range(last - 1, e0)) : -1;
        rst_at = do_rst ? ent[3] + 1 : -1;
        fc_score = sc;
        start    = 1'b1;
        do begin
            @(negedge clk);
            start    = (cyc == mid_n);
            pre_conv = 1'b0;
            if (cyc == rst_at) begin
                rst   = 1'b1;
                start = 1'b1;
                exp_q.delete();
                @(negedge clk);
                rst     = 1'b0;
                start   = 1'b0;
                m_score = 16'sd0;
                m_cls   = 1'b0;
                check_val("reset_midrun_outputs", outs(), 64'd0);
                break;
            end
        end while (cyc < last);
    endtask

    initial begin : driver
        logic signed [15:0] sc;
        bit pre;
        int r;
        rst = 1'b1; start = 1'b0; fc_score = 16'sd0; pre_conv = 1'b0;
        nchecks = 0; npass = 0; m_score = 16'sd0; m_cls = 1'b0;
        set_cfg(1, 1, 1, 1, 4'b0000);
        repeat (3) @(negedge clk);
        check_val("reset_state", outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal best-case run, positive score.
        run(16'sd37, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        // Variable latencies, held-level dones, negative score, ignored mid-run start.
        set_cfg(10, 3, 50, 7, 4'b1111);
        run(-16'sd5, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        // GAP never completes in time.
        set_cfg(1, 1, T + 5, 1, 4'b0000);
        run(16'sd99, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_val("error_sticky_in_err", {60'd0, error, debug_state}, 64'd14);
        // Recovery from ERR; pool done lands exactly on the timeout cycle.
        set_cfg(2, T - 1, 1, 1, 4'b0000);
        run(16'sd123, 1'b0, 1'b0, 1'b0);
        // conv_done held high across start.
        set_cfg(0, 2, 2, 2, 4'b0001);
        run(-16'sd300, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        // Reset in FC with start high, then a clean run and a zero-score run back to back.
        set_cfg(2, 2, 2, 12, 4'b0000);
        run(16'sd555, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        set_cfg(1, 1, 1, 1, 4'b0000);
        run(16'sd41, 1'b0, 1'b0, 1'b0);
        run(16'sd0, 1'b0, 1'b0, 1'b0);

        repeat (30) begin
            for (int s = 0; s < 4; s++) begin
                lvl[s] = ($urandom_range(1, 0) == 1);
                r = int'($urandom_range(7, 0));
                if (r == 0)      lat[s] = T + $urandom_range(6, 0);
                else if (r == 1) lat[s] = T - 1;
                else             lat[s] = $urandom_range(12, lvl[s] ? 0 : 1);
            end
            pre = lvl[0] && (lat[0] == 0) && ($urandom_range(1, 0) == 1);
            sc  = 16'($urandom);
            if ($urandom_range(5, 0) == 0) sc = 16'sd0;
            run(sc, ($urandom_range(1, 0) == 1), pre, 1'b0);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        repeat (T + 40) @(negedge clk);
        check_val("expected_events_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
